// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an N-bit up-counter: start/pause/resume/abort, programmable terminal value,
// one-shot or auto-reload. Optional prescaler is enabled by defining PRESCALE_EN (ratio set by PS).
module counter_seq_ctrl #(
    parameter int N  = 7
`ifdef PRESCALE_EN
    ,
    parameter int PS = 4
`endif
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         pause,
    input  logic         abort,
    input  logic         auto_reload,
    input  logic [N-1:0] period,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t       state_q;
    logic [N-1:0] count_q;
    logic [N-1:0] period_q;
    logic         busy_q;
    logic         done_q;
    logic         tick_s;
    logic         at_term_s;
    logic         tc_s;

`ifdef PRESCALE_EN
    localparam int PW = (PS > 1) ? $clog2(PS) : 1;
    logic [PW-1:0] pre_q;

    assign tick_s = (pre_q == PW'(PS - 1));

    // Prescaler: restarts with each fresh run or abort, runs only while counting
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pre_q <= '0;
        end else if (abort) begin
            pre_q <= '0;
        end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            pre_q <= '0;
        end else if (state_q == ST_RUN && !pause) begin
            pre_q <= tick_s ? '0 : pre_q + PW'(1);
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    assign at_term_s = (count_q == period_q);
    assign tc_s      = (state_q == ST_RUN) & at_term_s & ~pause & ~abort & tick_s;

    // Control FSM owning count, latched period and the status flags
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            period_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        period_q <= period;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_q <= ST_PAUSE;
                    end else if (tick_s) begin
                        if (!at_term_s) begin
                            count_q <= count_q + N'(1);
                        end else if (auto_reload) begin
                            count_q <= '0;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign tc    = tc_s;
    assign busy  = busy_q;
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed, table-driven bench for counter_seq_ctrl (N=7); inputs change on falling edges and
// outputs are checked shortly after, so each record describes one clock cycle.
module tb_counter_seq_ctrl;

    localparam int N = 7;
    localparam logic [1:0] S_I = 2'b00;
    localparam logic [1:0] S_R = 2'b01;
    localparam logic [1:0] S_P = 2'b10;
    localparam logic [1:0] S_D = 2'b11;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         pause;
    logic         abort;
    logic         auto_reload;
    logic [N-1:0] period;
    logic [N-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         st;
        logic         pa;
        logic         ab;
        logic         ar;
        logic [N-1:0] per;
        logic [N-1:0] c;
        logic         tc;
        logic [1:0]   s;
    } vec_t;

    vec_t vecs[$];

    counter_seq_ctrl #(.N(N)) dut (
        .clk(clk), .clr(clr), .start(start), .pause(pause), .abort(abort),
        .auto_reload(auto_reload), .period(period), .count(count), .tc(tc),
        .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic add(input int st, input int pa, input int ab, input int ar, input int per,
                       input int c, input int t, input logic [1:0] s);
        vec_t v;
        v.st = st[0]; v.pa = pa[0]; v.ab = ab[0]; v.ar = ar[0];
        v.per = per[N-1:0]; v.c = c[N-1:0]; v.tc = t[0]; v.s = s;
        vecs.push_back(v);
    endtask

    task automatic drive(input int st, input int pa, input int ab, input int ar, input int per);
        @(negedge clk);
        start = st[0]; pause = pa[0]; abort = ab[0]; auto_reload = ar[0]; period = per[N-1:0];
        #1;
    endtask

    task automatic check(input string name, input int c, input int t, input logic [1:0] s);
        logic eb, ed;
        eb = (s == S_R) || (s == S_P);
        ed = (s == S_D);
        total++;
        if (count !== c[N-1:0] || tc !== t[0] || busy !== eb || done !== ed || state !== s) begin
            bad++;
            $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b state=%b want count=%0d tc=%b busy=%b done=%b state=%b",
                     name, count, tc, busy, done, state, c, t[0], eb, ed, s);
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0; period = '0;
        #15;
        clr = 1'b0;
        @(negedge clk); #1;
        check("reset", 0, 0, S_I);

`ifdef PRESCALE_EN
        drive(1, 0, 0, 1, 2);
        check("pre_start", 0, 0, S_I);
        for (int j = 0; j < 16; j++) begin
            drive(0, 0, 0, 1, 2);
            check($sformatf("pre_cyc%0d", j), (j % 12) / 4, ((j % 12) == 11) ? 1 : 0, S_R);
        end
`else
        // one-shot, period 10
        add(1, 0, 0, 0, 10, 0, 0, S_I);
        for (int i = 0; i <= 10; i++) add(0, 0, 0, 0, 10, i, (i == 10) ? 1 : 0, S_R);
        add(0, 0, 0, 0, 5, 10, 0, S_D);
        add(0, 0, 0, 0, 5, 10, 0, S_D);
        // auto-reload, period 3, restarted from DONE
        add(1, 0, 0, 1, 3, 10, 0, S_D);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 3, i % 4, ((i % 4) == 3) ? 1 : 0, S_R);
        add(0, 0, 1, 1, 3, 0, 0, S_R);
        // pause at 4 for five cycles with a period change, then resume
        add(1, 0, 0, 0, 20, 0, 0, S_I);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 20, i, 0, S_R);
        add(0, 1, 0, 0, 20, 4, 0, S_R);
        for (int i = 0; i < 5; i++) add(0, i % 2, 0, 0, 9, 4, 0, S_P);
        add(1, 0, 0, 0, 9, 4, 0, S_P);
        add(0, 0, 0, 0, 9, 4, 0, S_R);
        add(0, 0, 0, 0, 9, 5, 0, S_R);
        add(0, 0, 0, 0, 9, 6, 0, S_R);
        // abort wins over simultaneous pause and start
        add(1, 1, 1, 0, 9, 7, 0, S_R);
        add(0, 0, 0, 0, 9, 0, 0, S_I);
        // pause exactly at terminal count suppresses tc
        add(1, 0, 0, 0, 2, 0, 0, S_I);
        add(0, 0, 0, 0, 2, 0, 0, S_R);
        add(0, 0, 0, 0, 2, 1, 0, S_R);
        add(0, 1, 0, 0, 2, 2, 0, S_R);
        add(0, 0, 0, 0, 2, 2, 0, S_P);
        add(1, 0, 0, 0, 5, 2, 0, S_P);
        add(0, 0, 0, 0, 5, 2, 1, S_R);
        add(0, 0, 0, 0, 5, 2, 0, S_D);
        // period 0 with auto-reload: tc every RUN cycle
        add(1, 0, 0, 1, 0, 2, 0, S_D);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 0, 1, S_R);
        add(0, 0, 1, 1, 0, 0, 0, S_R);
        add(0, 0, 0, 0, 0, 0, 0, S_I);

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].pa, vecs[i].ab, vecs[i].ar, vecs[i].per);
            check($sformatf("vec%0d", i), vecs[i].c, vecs[i].tc, vecs[i].s);
        end

        // full-range period reaches 127 without wrapping
        drive(1, 0, 0, 0, 127);
        check("max_start", 0, 0, S_I);
        for (int i = 0; i <= 127; i++) begin
            drive(0, 0, 0, 0, 127);
            if (i == 0 || i >= 125) check($sformatf("max_c%0d", i), i, (i == 127) ? 1 : 0, S_R);
        end
        drive(0, 0, 0, 0, 127);
        check("max_done", 127, 0, S_D);

        // asynchronous clear mid-run at count 5
        drive(1, 0, 0, 0, 10);
        check("clr_start", 127, 0, S_D);
        for (int i = 0; i <= 5; i++) drive(0, 0, 0, 0, 10);
        check("clr_pre", 5, 0, S_R);
        #1 clr = 1'b1;
        #1 check("clr_async", 0, 0, S_I);
        #1 clr = 1'b0;
        drive(0, 0, 0, 0, 10);
        check("clr_after", 0, 0, S_I);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Sequencing controller for an N-bit up-counter: start/pause/resume/abort control, programmable terminal value, one-shot or auto-reload mode.
- Sits between a control source (CPU register bank or top-level FSM) and the count datapath; owns the count register and the terminal-count event.
- Downstream logic consumes count, tc, busy and done.

Parameters:
N, 7, count and period width in bits.
PS, 4, prescale ratio; exists only when PRESCALE_EN is defined. Legal range 1..255.

Ports:
clk  input  1  system clock; all state updates on rising edge.
clr  input  1  asynchronous, active-high reset.
start  input  1  start from IDLE/DONE; resume from PAUSE.
pause  input  1  freeze counting while in RUN.
abort  input  1  return to IDLE from any state.
auto_reload  input  1  1 = periodic, 0 = one-shot; sampled at each terminal event.
period  input  N  terminal count value; latched into period_r on start from IDLE/DONE.
count  output  N  current count (registered).
tc  output  1  terminal-count event, one cycle wide.
busy  output  1  high in RUN or PAUSE.
done  output  1  high in DONE.
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, count=0, period_r=0; tc=0, busy=0, done=0.
- Priority per edge: abort > pause > start > increment.
- Any state, abort=1: next edge -> IDLE, count=0.
- IDLE, start=1: -> RUN, period_r<=period, count<=0.
- RUN, no pause/abort, count!=period_r: count<=count+1.
- RUN, pause=1: -> PAUSE, count holds; no increment on that edge.
- RUN, count==period_r, no pause/abort (terminal event):
  - tc=1 for that cycle; tc = (state==RUN) & (count==period_r) & ~pause & ~abort.
  - auto_reload=1: count<=0, stay in RUN.
  - auto_reload=0: -> DONE, count holds period_r.
- RUN, start=1: ignored; no restart and no relatch.
- PAUSE, start=1: -> RUN; count and period_r unchanged. pause=1 in PAUSE has no effect.
- DONE, start=1: -> RUN, period_r<=period, count<=0. Otherwise DONE holds.
- Latency, one-shot: start sampled at edge k, period=P.
  - count=0 after edge k.
  - count=P after edge k+P; tc high during that cycle.
  - DONE after edge k+P+1.
- period=0: tc high in the first RUN cycle; auto-reload then produces tc every cycle.
- Width rules:
  - count never exceeds period_r, so no wrap/overflow.
  - period=2^N-1 is legal and gives the full range.
  - period input changes outside a start edge are ignored.
- busy = (state==RUN) | (state==PAUSE); done = (state==DONE).
- Reset mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
PRESCALE_EN
- Defined:
  - Internal prescaler counter, width ceil(log2 PS), cleared on start from IDLE/DONE and on abort; holds in PAUSE.
  - In RUN, count advances and the terminal event is evaluated only on tick cycles (prescaler == PS-1).
  - tc qualified by tick, so the period is (P+1)*PS cycles.
- Not defined: tick is constant 1; behaviour exactly as above.

Test Plan:
1. clr=1 for 15 ns, then release -> state=00, count=0, tc=0, busy=0, done=0; asserting clr mid-RUN with count=5 immediately returns count to 0.
2. One-shot, N=7, period=10, pulse start -> count 0..10 on consecutive edges; tc high only while count=10; next edge state=DONE, count holds 10, done=1.
3. Auto-reload, period=3 -> count sequence 0,1,2,3,0,1,2,3; tc every 4th cycle; busy stays 1.
4. Pause at count=4 for 5 cycles, then start -> count holds 4 in PAUSE; resumes 5,6,...; period change during PAUSE has no effect.
5. Abort with simultaneous pause and start at count=7 -> IDLE, count=0; pause=1 at count==period -> no tc, state PAUSE.
6. Edge cases: period=0 with auto_reload=1 -> tc high every RUN cycle. period=127 -> reaches 127 without wrap. With PRESCALE_EN, PS=4, period=2 -> tc after 12 cycles.
